// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports and the data_memory pins around data_mem_arbiter.
// slave: the arbiter's view; master: requesters plus the memory that surround it.
interface data_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_err;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_err;

  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rd,
    output m0_ack, m0_rdata, m0_err,
    output m1_ack, m1_rdata, m1_err,
    output mem_we, mem_re, mem_a, mem_wd
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rd,
    input  m0_ack, m0_rdata, m0_err,
    input  m1_ack, m1_rdata, m1_err,
    input  mem_we, mem_re, mem_a, mem_wd
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin two-port arbiter/sequencer for the single-port data memory, 3 cycles per access.
// Define ARB_ADDR_CHECK_EN to flag and suppress accesses outside [BASE_ADDR, BASE_ADDR+DEPTH).
module data_mem_arbiter #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h3E0,
  parameter int unsigned       DEPTH     = 128
) (
  input logic               clk,
  input logic               rst,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StServe, StResp} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [DATA_W-1:0] mem_wd_q, mem_wd_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        err_o_q, err_o_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              gnt_valid;
  logic              gnt_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_err;
  logic [DATA_W-1:0] rd_val;

  if (DEPTH == 0 || BASE_ADDR[1:0] != 2'b00) begin : g_bad_cfg
    $error("data_mem_arbiter: DEPTH must be nonzero and BASE_ADDR word aligned");
  end

  // On a tie the port that did not win last time goes first.
  always_comb begin
    gnt_valid = bus.m0_req | bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      gnt_port = ~last_grant_q;
    end else begin
      gnt_port = bus.m1_req;
    end
    sel_we    = gnt_port ? bus.m1_we    : bus.m0_we;
    sel_addr  = gnt_port ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = gnt_port ? bus.m1_wdata : bus.m0_wdata;
  end

`ifdef ARB_ADDR_CHECK_EN
  logic [ADDR_W-1:0] addr_off;
  // Offset compare in ADDR_W bits; the explicit lower bound stops wrap-around passing.
  assign addr_off = sel_addr - BASE_ADDR;
  assign sel_err  = (sel_addr < BASE_ADDR) || (addr_off >= ADDR_W'(DEPTH));
`else
  assign sel_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    err_d        = err_q;
    mem_a_d      = mem_a_q;
    mem_wd_d     = mem_wd_q;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;
    ack_d        = 2'b00;
    err_o_d      = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    rd_val       = err_q ? '0 : bus.mem_rd;

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          state_d      = StServe;
          port_d       = gnt_port;
          last_grant_d = gnt_port;
          we_d         = sel_we;
          err_d        = sel_err;
          mem_a_d      = sel_addr;
          mem_wd_d     = sel_wdata;
          mem_we_d     = sel_we & ~sel_err;
          mem_re_d     = ~sel_we & ~sel_err;
        end
      end
      StServe: begin
        state_d          = StResp;
        ack_d[port_q]    = 1'b1;
        err_o_d[port_q]  = err_q;
        // Writes leave rdata alone; an errored read returns zero.
        if (!we_q) begin
          if (port_q) begin
            rdata1_d = rd_val;
          end else begin
            rdata0_d = rd_val;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Async reset also kills mem_we at once, so an abandoned write never lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      mem_a_q      <= '0;
      mem_wd_q     <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      ack_q        <= 2'b00;
      err_o_q      <= 2'b00;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      err_q        <= err_d;
      mem_a_q      <= mem_a_d;
      mem_wd_q     <= mem_wd_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      ack_q        <= ack_d;
      err_o_q      <= err_o_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign bus.m0_ack   = ack_q[0];
  assign bus.m1_ack   = ack_q[1];
  assign bus.m0_err   = err_o_q[0];
  assign bus.m1_err   = err_o_q[1];
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_re   = mem_re_q;
  assign bus.mem_a    = mem_a_q;
  assign bus.mem_wd   = mem_wd_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: vector table of single transactions plus
// hand-written round-robin and reset-during-SERVE sequences, against a small memory model.
module tb_data_mem_arbiter;
  localparam logic [31:0] BASE = 32'h3E0;

  logic clk = 1'b0;
  logic rst;
  logic mem_load;
  int   n_tests = 0;
  int   n_fail = 0;
  int   we_cnt = 0;
  int   re_cnt = 0;
  logic [31:0] mem [128];

  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  data_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .DEPTH(128)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'd128);
  endfunction

  // data_memory stand-in: combinational read, write on negedge.
  always_comb begin
    bus.mem_rd = in_rng(bus.mem_a) ? mem[7'(bus.mem_a - BASE)] : (32'hBAD0_0000 ^ bus.mem_a);
  end

  always @(negedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
      mem[0] <= 32'hAABBCCDD;
      mem[8] <= 32'h21212121;
    end else if (bus.mem_we && in_rng(bus.mem_a)) begin
      mem[7'(bus.mem_a - BASE)] <= bus.mem_wd;
    end
    if (bus.mem_we) we_cnt <= we_cnt + 1;
    if (bus.mem_re) re_cnt <= re_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_txn(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                        output bit err, output bit other_ack, output int nwe, output int nre);
    int we0;
    int re0;
    @(negedge clk);
    we0 = we_cnt;
    re0 = re_cnt;
    if (port) begin
      bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_req = 1'b1;
    end else begin
      bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_req = 1'b1;
    end
    lat = -1;
    other_ack = 1'b0;
    rdata = 32'hx;
    err = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (port ? bus.m0_ack : bus.m1_ack) other_ack = 1'b1;
      if (port ? bus.m1_ack : bus.m0_ack) begin
        lat   = i;
        rdata = port ? bus.m1_rdata : bus.m0_rdata;
        err   = port ? bus.m1_err : bus.m0_err;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    nwe = we_cnt - we0;
    nre = re_cnt - re0;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_we;
    int          exp_re;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int          lat;
    logic [31:0] rdata;
    bit          err;
    bit          oack;
    int          nwe;
    int          nre;
    int          ack_at [8];
    bit          ack_port [8];
    logic [31:0] ack_data [8];
    int          n_acks;
    bit          both_ack;
    bit          ack_seen;

    vecs[0] = '{1'b0, 1'b0, 32'h3E0, 32'h0,        32'hAABBCCDD, 1'b0, 0, 1};
    vecs[1] = '{1'b1, 1'b1, 32'h3E4, 32'h12345678, 32'h0,        1'b0, 1, 0};
    vecs[2] = '{1'b1, 1'b0, 32'h3E4, 32'h0,        32'h12345678, 1'b0, 0, 1};
    vecs[3] = '{1'b0, 1'b1, 32'h3EC, 32'h0BADF00D, 32'hAABBCCDD, 1'b0, 1, 0};
    vecs[4] = '{1'b0, 1'b0, 32'h3EC, 32'h0,        32'h0BADF00D, 1'b0, 0, 1};
    vecs[5] = '{1'b1, 1'b0, 32'h3E0, 32'h0,        32'hAABBCCDD, 1'b0, 0, 1};
`ifdef ARB_ADDR_CHECK_EN
    vecs[6] = '{1'b0, 1'b0, 32'h3DC, 32'h0,        32'h0,        1'b1, 0, 0};
    vecs[7] = '{1'b0, 1'b0, 32'h5E0, 32'h0,        32'h0,        1'b1, 0, 0};
    vecs[8] = '{1'b1, 1'b1, 32'h5E0, 32'hDEADBEEF, 32'hAABBCCDD, 1'b1, 0, 0};
`else
    vecs[6] = '{1'b0, 1'b0, 32'h3DC, 32'h0,        32'hBAD003DC, 1'b0, 0, 1};
    vecs[7] = '{1'b0, 1'b0, 32'h5E0, 32'h0,        32'hBAD005E0, 1'b0, 0, 1};
    vecs[8] = '{1'b1, 1'b1, 32'h5E0, 32'hDEADBEEF, 32'hAABBCCDD, 1'b0, 1, 0};
`endif

    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    rst = 1'b1;
    mem_load = 1'b1;
    repeat (2) @(negedge clk);
    mem_load = 1'b0;
    rst = 1'b0;

    // Reset values, held over five idle cycles.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rst_ctl", {26'd0, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err,
                        bus.mem_we, bus.mem_re}, 32'h0);
      check("rst_m0_rdata", bus.m0_rdata, 32'h0);
      check("rst_m1_rdata", bus.m1_rdata, 32'h0);
      check("rst_mem_a", bus.mem_a, 32'h0);
      check("rst_mem_wd", bus.mem_wd, 32'h0);
    end

    // Single transactions from the table.
    for (int v = 0; v < 9; v++) begin
      do_txn(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata, lat, rdata, err, oack,
             nwe, nre);
      check($sformatf("v%0d_latency", v), 32'(lat), 32'd2);
      check($sformatf("v%0d_rdata", v), rdata, vecs[v].exp_rdata);
      check($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_other_ack", v), 32'(oack), 32'd0);
      check($sformatf("v%0d_mem_we_cycles", v), 32'(nwe), 32'(vecs[v].exp_we));
      check($sformatf("v%0d_mem_re_cycles", v), 32'(nre), 32'(vecs[v].exp_re));
    end

    // Round-robin: fresh reset so port 0 wins the first tie, both requests held.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.m0_we = 1'b0; bus.m0_addr = 32'h3E0;
    bus.m1_we = 1'b0; bus.m1_addr = 32'h3E4;
    bus.m0_req = 1'b1;
    bus.m1_req = 1'b1;
    n_acks = 0;
    both_ack = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.m0_ack && bus.m1_ack) both_ack = 1'b1;
      if ((bus.m0_ack || bus.m1_ack) && n_acks < 8) begin
        ack_at[n_acks]   = i;
        ack_port[n_acks] = bus.m1_ack;
        ack_data[n_acks] = bus.m1_ack ? bus.m1_rdata : bus.m0_rdata;
        n_acks++;
      end
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    check("rr_ack_count", 32'(n_acks), 32'd4);
    check("rr_both_ack", 32'(both_ack), 32'd0);
    for (int k = 0; k < 4; k++) begin
      if (k < n_acks) begin
        check($sformatf("rr%0d_port", k), 32'(ack_port[k]), 32'(k % 2));
        check($sformatf("rr%0d_cycle", k), 32'(ack_at[k]), 32'(2 + 3 * k));
        check($sformatf("rr%0d_rdata", k), ack_data[k],
              (k % 2 == 0) ? 32'hAABBCCDD : 32'h12345678);
      end
    end
    repeat (3) @(negedge clk);

    // Reset during SERVE of a write: no ack, no memory update.
    bus.m0_we = 1'b1; bus.m0_addr = 32'h3E8; bus.m0_wdata = 32'hFFFFFFFF;
    bus.m0_req = 1'b1;
    @(posedge clk);
    #1;
    check("serve_mem_we", 32'(bus.mem_we), 32'd1);
    check("serve_mem_a", bus.mem_a, 32'h3E8);
    rst = 1'b1;
    bus.m0_req = 1'b0;
    #1;
    check("rst_mid_mem_we", 32'(bus.mem_we), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ack_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.m0_ack || bus.m1_ack) ack_seen = 1'b1;
    end
    check("rst_mid_no_ack", 32'(ack_seen), 32'd0);
    check("rst_mid_mem8", mem[8], 32'h21212121);
    do_txn(1'b0, 1'b0, 32'h3E8, 32'h0, lat, rdata, err, oack, nwe, nre);
    check("rst_mid_readback_latency", 32'(lat), 32'd2);
    check("rst_mid_readback", rdata, 32'h21212121);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
